// File: rtl/uart_program_loader.sv
// UART program loader: receives a SYNC/LEN/DATA/CSUM framed image, writes it into
// CPU memory from address 0x00 and releases cpu_run only after a checksum-valid load.
//   state        | meaning
//   RX_IDLE      | line idle, waiting for a falling edge
//   RX_START     | half-bit wait, confirm start bit
//   RX_DATA      | sampling 8 data bits, LSB first
//   RX_STOP      | sampling stop bit
//   F_WAIT_SYNC  | CPU held, waiting for 0xA5
//   F_LEN        | next byte is the data length (0 = 256)
//   F_DATA       | writing data bytes into memory
//   F_CSUM       | next byte is judged against the running sum
//   F_RUN        | image valid, CPU running, watching for a new 0xA5
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int TIMEOUT_CLKS = 1200000
) (
  input  logic       CLK_12MHz,
  input  logic       RST_n,
  input  logic       UART_RX,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_run,
  output logic       loading,
  output logic       load_err
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] F_WAIT_SYNC = 3'd0;
  localparam logic [2:0] F_LEN       = 3'd1;
  localparam logic [2:0] F_DATA      = 3'd2;
  localparam logic [2:0] F_CSUM      = 3'd3;
  localparam logic [2:0] F_RUN       = 3'd4;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  logic          r_rx_meta, r_rx_sync;
  logic [1:0]    r_rx_state;
  logic [BW-1:0] r_bit_tmr;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_rx_valid, r_frm_err;

  logic [2:0]    r_f_state;
  logic [8:0]    r_cnt;
  logic [7:0]    r_addr, r_sum;
  logic [TW-1:0] r_tmo;
  logic          r_mem_we, r_cpu_run, r_loading, r_load_err;
  logic [7:0]    r_mem_addr, r_mem_wdata;
  logic          w_tmo_fire, w_abort;

  // Synchronizer resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge CLK_12MHz) begin
    if (!RST_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= UART_RX;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge CLK_12MHz) begin
    if (!RST_n) begin
      r_rx_state <= RX_IDLE;
      r_bit_tmr  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_rx_valid <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_frm_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_sync) begin
            r_rx_state <= RX_START;
            r_bit_tmr  <= BW'(CLKS_PER_BIT / 2 - 1);
          end
        end
        RX_START: begin
          if (r_bit_tmr == '0) begin
            if (!r_rx_sync) begin
              r_rx_state <= RX_DATA;
              r_bit_tmr  <= BW'(CLKS_PER_BIT - 1);
              r_bit_idx  <= '0;
            end else begin
              r_rx_state <= RX_IDLE;
            end
          end else begin
            r_bit_tmr <= r_bit_tmr - BW'(1);
          end
        end
        RX_DATA: begin
          if (r_bit_tmr == '0) begin
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_tmr <= BW'(CLKS_PER_BIT - 1);
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_bit_tmr <= r_bit_tmr - BW'(1);
          end
        end
        default: begin
          if (r_bit_tmr == '0) begin
            r_rx_valid <= r_rx_sync;
            r_frm_err  <= !r_rx_sync;
            r_rx_state <= RX_IDLE;
          end else begin
            r_bit_tmr <= r_bit_tmr - BW'(1);
          end
        end
      endcase
    end
  end

  // Inter-byte watchdog: reloaded by every received byte, only counts down mid-frame.
  always_ff @(posedge CLK_12MHz) begin
    if (!RST_n) begin
      r_tmo <= '0;
    end else if (!r_loading || r_rx_valid) begin
      r_tmo <= TW'(TIMEOUT_CLKS - 1);
    end else if (r_tmo != '0) begin
      r_tmo <= r_tmo - TW'(1);
    end
  end

  assign w_tmo_fire = r_loading && (r_tmo == '0) && !r_rx_valid;
  assign w_abort    = r_loading && (r_frm_err || w_tmo_fire);

  always_ff @(posedge CLK_12MHz) begin
    if (!RST_n) begin
      r_f_state   <= F_WAIT_SYNC;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_sum       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_run   <= 1'b0;
      r_loading   <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_abort) begin
        r_load_err <= 1'b1;
        r_loading  <= 1'b0;
        r_f_state  <= F_WAIT_SYNC;
      end else if (r_rx_valid) begin
        case (r_f_state)
          F_WAIT_SYNC, F_RUN: begin
            if (r_shift == SYNC_BYTE) begin
              r_load_err <= 1'b0;
              r_cpu_run  <= 1'b0;
              r_loading  <= 1'b1;
              r_addr     <= '0;
              r_sum      <= '0;
              r_f_state  <= F_LEN;
            end
          end
          F_LEN: begin
            r_cnt     <= (r_shift == 8'd0) ? 9'd256 : {1'b0, r_shift};
            r_f_state <= F_DATA;
          end
          F_DATA: begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_shift;
            r_sum       <= r_sum + r_shift;
            r_addr      <= r_addr + 8'd1;
            r_cnt       <= r_cnt - 9'd1;
            if (r_cnt == 9'd1) r_f_state <= F_CSUM;
          end
          F_CSUM: begin
            r_loading <= 1'b0;
            if (r_shift == r_sum) begin
              r_cpu_run <= 1'b1;
              r_f_state <= F_RUN;
            end else begin
              r_load_err <= 1'b1;
              r_f_state  <= F_WAIT_SYNC;
            end
          end
          default: r_f_state <= F_WAIT_SYNC;
        endcase
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_run   = r_cpu_run;
  assign loading   = r_loading;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: serial byte driver, byte-level frame model with an
// expected-write queue, and a per-cycle compare process.
module tb_uart_program_loader;
  localparam int CPB = 8;
  localparam int TMO = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       mem_we, cpu_run, loading, load_err;
  logic [7:0] mem_addr, mem_wdata;

  always #5 clk = ~clk;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .CLK_12MHz(clk), .RST_n(rst_n), .UART_RX(rx),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .loading(loading), .load_err(load_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [15:0] exp_q[$];
  int m_loading, m_need_len, m_rem, m_addr, m_sum, m_run, m_err;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_loading = 0; m_need_len = 0; m_rem = 0; m_addr = 0; m_sum = 0; m_run = 0; m_err = 0;
    exp_q.delete();
  endtask

  // Frame rules applied one byte at a time.
  task automatic model_byte(input logic [7:0] b);
    if (m_loading == 0) begin
      if (b == 8'hA5) begin
        m_loading = 1; m_need_len = 1; m_err = 0; m_run = 0; m_addr = 0; m_sum = 0;
      end
    end else if (m_need_len != 0) begin
      m_rem = (b == 8'd0) ? 256 : int'(b);
      m_need_len = 0;
    end else if (m_rem > 0) begin
      exp_q.push_back({8'(m_addr), b});
      m_addr = (m_addr + 1) % 256;
      m_sum  = (m_sum + int'(b)) % 256;
      m_rem--;
    end else begin
      m_loading = 0;
      if (int'(b) == m_sum) m_run = 1;
      else m_err = 1;
    end
  endtask

  task automatic model_abort();
    if (m_loading != 0) begin
      m_loading = 0; m_err = 1; m_run = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    chk_en = 1'b0;
    if (stop_ok) model_byte(b);
    else model_abort();
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_ok;
    idle(CPB);
    rx = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic sb(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  task automatic rgap();
    if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 20));
  endtask

  task automatic drained(input string name);
    idle(20);
    chk(name, exp_q.size(), 0);
  endtask

  // Per-cycle compare, sampled 2 ns after the rising edge.
  initial forever begin
    @(posedge clk);
    #2;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_mem_we", 1, 0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("mem_addr", int'(mem_addr), int'(e[15:8]));
        chk("mem_wdata", int'(mem_wdata), int'(e[7:0]));
      end
    end
    if (chk_en) begin
      chk("cpu_run", int'(cpu_run), m_run);
      chk("loading", int'(loading), m_loading);
      chk("load_err", int'(load_err), m_err);
    end
  end

  initial begin
    idle(90000);
    $display("FAIL watchdog: cycle budget exhausted before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, sum, j;
    int len;
    m_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    idle(4);
    chk("rst_cpu_run", int'(cpu_run), 0);
    chk("rst_loading", int'(loading), 0);
    chk("rst_load_err", int'(load_err), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(10);

    // Basic 3-byte image
    sb(8'hA5); sb(8'h03); sb(8'h11); sb(8'h22); sb(8'h33); sb(8'h66);
    drained("t1_writes");
    chk("t1_cpu_run", int'(cpu_run), 1);
    chk("t1_load_err", int'(load_err), 0);
    chk("t1_mem_addr", int'(mem_addr), 8'h02);
    chk("t1_mem_wdata", int'(mem_wdata), 8'h33);

    // Bad checksum
    sb(8'hA5); sb(8'h02); sb(8'h10); sb(8'h20); sb(8'h31);
    drained("t2_writes");
    chk("t2_load_err", int'(load_err), 1);
    chk("t2_cpu_run", int'(cpu_run), 0);
    chk("t2_loading", int'(loading), 0);

    // LEN = 0 means 256 bytes, address wraps only after the last byte
    sb(8'hA5); sb(8'h00);
    for (int i = 0; i < 256; i++) sb(8'(i));
    sb(8'h80);
    drained("t3_writes");
    chk("t3_mem_addr", int'(mem_addr), 8'hFF);
    chk("t3_mem_wdata", int'(mem_wdata), 8'hFF);
    chk("t3_cpu_run", int'(cpu_run), 1);

    // Timeout mid-frame, then recovery
    sb(8'hA5); sb(8'h04); sb(8'h01); sb(8'h02);
    idle(250);
    chk("t4_still_loading", int'(loading), 1);
    chk_en = 1'b0;
    idle(TMO + 200);
    model_abort();
    chk_en = 1'b1;
    chk("t4_tmo_err", int'(load_err), 1);
    chk("t4_tmo_loading", int'(loading), 0);
    sb(8'hA5); sb(8'h01); sb(8'h5A); sb(8'h5A);
    drained("t4_writes");
    chk("t4_recover_err", int'(load_err), 0);
    chk("t4_recover_run", int'(cpu_run), 1);

    // Non-SYNC bytes while running are ignored; SYNC restarts the load
    sb(8'h00); sb(8'hFF);
    chk("t5_run_kept", int'(cpu_run), 1);
    sb(8'hA5);
    chk("t5_run_drop", int'(cpu_run), 0);
    sb(8'h01); sb(8'h7E); sb(8'h7E);
    drained("t5_writes");
    chk("t5_run_again", int'(cpu_run), 1);
    chk("t5_mem_addr", int'(mem_addr), 8'h00);
    chk("t5_mem_wdata", int'(mem_wdata), 8'h7E);

    // 2-cycle glitch mid-frame must not produce a byte
    sb(8'hA5); sb(8'h02); sb(8'h11);
    rx = 1'b0; idle(2); rx = 1'b1;
    idle(100);
    sb(8'h22); sb(8'h33);
    drained("glitch_writes");
    chk("glitch_run", int'(cpu_run), 1);

    // Framing error mid-frame
    sb(8'hA5); sb(8'h03); sb(8'h01);
    send_byte(8'h55, 1'b0);
    idle(40);
    chk("frm_err", int'(load_err), 1);
    chk("frm_loading", int'(loading), 0);
    sb(8'hA5); sb(8'h01); sb(8'h33); sb(8'h33);
    drained("frm_writes");
    chk("frm_recover_run", int'(cpu_run), 1);

    // Reset pulse in the middle of a data byte
    sb(8'hA5); sb(8'h03); sb(8'h11);
    chk_en = 1'b0;
    rx = 1'b0;
    idle(30);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    rx = 1'b1;
    chk("rstmid_loading", int'(loading), 0);
    chk("rstmid_cpu_run", int'(cpu_run), 0);
    chk("rstmid_mem_addr", int'(mem_addr), 0);
    chk("rstmid_mem_wdata", int'(mem_wdata), 0);
    chk("rstmid_writes", exp_q.size(), 0);
    m_reset();
    chk_en = 1'b1;
    idle(100);
    sb(8'hA5); sb(8'h02); sb(8'hAA); sb(8'hBB); sb(8'h65);
    drained("rstmid_reload_writes");
    chk("rstmid_reload_run", int'(cpu_run), 1);
    chk("rstmid_reload_addr", int'(mem_addr), 8'h01);

    // Random frames with junk between them and random inter-byte gaps
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h5A;
        sb(j);
        rgap();
      end
      sb(8'hA5); rgap();
      len = $urandom_range(1, 12);
      sb(8'(len)); rgap();
      sum = 8'h00;
      for (int k = 0; k < len; k++) begin
        d = 8'($urandom);
        sum = sum + d;
        sb(d);
        rgap();
      end
      if ($urandom_range(0, 3) == 0) sum = sum + 8'd1;
      sb(sum);
      idle($urandom_range(0, 30));
    end
    drained("rand_writes");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
